// File: rtl/ctrl_bubble_reg.sv
// ID/EX control-bundle pipeline register: captures decoded control each cycle and
// injects NOP bubbles on hazards, with stall/flush handling and a saturating bubble counter.
module ctrl_bubble_reg #(
  parameter int                CTRL_W      = 18,
  parameter logic [CTRL_W-1:0] NOP_VALUE   = '0,
  parameter int                MAX_BUBBLES = 3,
  parameter int                STAT_W      = 16,
  parameter int                CNT_W       = $clog2(MAX_BUBBLES + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [CTRL_W-1:0] CTRL_IN,
  input  logic              VALID_IN,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              BUBBLE_REQ,
  input  logic [CNT_W-1:0]  BUBBLE_CNT,
  output logic [CTRL_W-1:0] CTRL_OUT,
  output logic              VALID_OUT,
  output logic              HOLD_UPSTREAM,
  output logic              BUSY,
  output logic [STAT_W-1:0] BUBBLE_STAT
);

  typedef enum logic {IDLE, BUBBLE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BUBBLES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   eff;
  logic               live;
  logic [STAT_W-1:0]  stat_nxt;

  // Requests larger than the hardware limit are clamped, never rejected.
  assign eff  = (BUBBLE_CNT > MAX_C) ? MAX_C : BUBBLE_CNT;
  assign live = BUBBLE_REQ && (eff != '0);

  assign HOLD_UPSTREAM = !FLUSH && (STALL || (state == BUBBLE) || ((state == IDLE) && live));

  assign stat_nxt = (BUBBLE_STAT == '1) ? BUBBLE_STAT : BUBBLE_STAT + STAT_W'(1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      CTRL_OUT    <= NOP_VALUE;
      VALID_OUT   <= 1'b0;
      BUSY        <= 1'b0;
      BUBBLE_STAT <= '0;
    end else if (FLUSH) begin
      state     <= IDLE;
      cnt       <= '0;
      CTRL_OUT  <= NOP_VALUE;
      VALID_OUT <= 1'b0;
      BUSY      <= 1'b0;
    end else if (!STALL) begin
      case (state)
        IDLE: begin
          if (live) begin
            CTRL_OUT    <= NOP_VALUE;
            VALID_OUT   <= 1'b0;
            BUBBLE_STAT <= stat_nxt;
            if (eff > CNT_W'(1)) begin
              cnt   <= eff - CNT_W'(1);
              BUSY  <= 1'b1;
              state <= BUBBLE;
            end
          end else begin
            CTRL_OUT  <= VALID_IN ? CTRL_IN : NOP_VALUE;
            VALID_OUT <= VALID_IN;
          end
        end
        BUBBLE: begin
          // New requests are ignored here; the sequence is never extended.
          CTRL_OUT    <= NOP_VALUE;
          VALID_OUT   <= 1'b0;
          BUBBLE_STAT <= stat_nxt;
          cnt         <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
